// File: rtl/net_tx_arbiter.sv
// Frame-aware transmit arbiter: merges CH_NUM frame streams onto one MAC stream,
// holding each grant until the frame's last beat and inserting an optional idle gap.
module net_tx_arbiter #(
    parameter int CH_NUM     = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ARB_MODE   = 0,
    parameter int IFG_CYCLES = 0
) (
    input  logic                         logic_clk,
    input  logic                         logic_rst,
    input  logic [CH_NUM*DATA_WIDTH-1:0] src_data_in,
    input  logic [CH_NUM-1:0]            src_valid_in,
    output logic [CH_NUM-1:0]            src_ready_out,
    input  logic [CH_NUM-1:0]            src_last_in,
    output logic [DATA_WIDTH-1:0]        net_tmac_data_out,
    output logic                         net_tmac_valid_out,
    input  logic                         net_tmac_ready_in,
    output logic                         net_tmac_last_out,
    output logic [CH_NUM-1:0]            grant_out,
    output logic                         busy_out
);

    localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [7:0] GAP_LOAD = (IFG_CYCLES > 0) ? 8'(IFG_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE,
        FORWARD,
        GAP
    } state_t;

    state_t            r_state;
    logic [CH_NUM-1:0] r_grant;
    logic [IDX_W-1:0]  r_gidx;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [7:0]        r_gap_cnt;
    logic              r_busy;

    logic [IDX_W-1:0]  w_win_idx;
    logic [CH_NUM-1:0] w_win_oh;
    logic              w_fire;
    logic              w_frame_end;
    logic [IDX_W-1:0]  w_next_ptr;

    // Winner search starts at channel 0 in fixed mode, or at the rotating pointer in round-robin mode.
    always_comb begin : p_winner
        logic found;
        int   idx;
        found     = 1'b0;
        idx       = 0;
        w_win_idx = '0;
        w_win_oh  = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            idx = (ARB_MODE == 1) ? ((int'(r_rr_ptr) + k) % CH_NUM) : k;
            if (!found && src_valid_in[idx]) begin
                found         = 1'b1;
                w_win_idx     = IDX_W'(idx);
                w_win_oh[idx] = 1'b1;
            end
        end
    end

    assign w_fire      = (r_state == FORWARD) && src_valid_in[r_gidx] && net_tmac_ready_in;
    assign w_frame_end = w_fire && src_last_in[r_gidx];
    assign w_next_ptr  = (r_gidx == IDX_W'(CH_NUM - 1)) ? '0 : r_gidx + IDX_W'(1);

    always_comb begin
        net_tmac_data_out  = '0;
        net_tmac_valid_out = 1'b0;
        net_tmac_last_out  = 1'b0;
        src_ready_out      = '0;
        if (r_state == FORWARD) begin
            net_tmac_data_out     = src_data_in[r_gidx*DATA_WIDTH +: DATA_WIDTH];
            net_tmac_valid_out    = src_valid_in[r_gidx];
            net_tmac_last_out     = src_last_in[r_gidx];
            src_ready_out[r_gidx] = net_tmac_ready_in;
        end
    end

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_rr_ptr  <= '0;
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|src_valid_in) begin
                        r_state <= FORWARD;
                        r_grant <= w_win_oh;
                        r_gidx  <= w_win_idx;
                        r_busy  <= 1'b1;
                    end
                end
                FORWARD: begin
                    if (w_frame_end) begin
                        r_grant  <= '0;
                        r_rr_ptr <= w_next_ptr;
                        if (IFG_CYCLES > 0) begin
                            r_state   <= GAP;
                            r_gap_cnt <= GAP_LOAD;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (r_gap_cnt == 8'd0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_out = r_grant;
    assign busy_out  = r_busy;

endmodule

// File: tb/tb_net_tx_arbiter.sv
// Directed bench for net_tx_arbiter: three instances (fixed priority, 3-channel round-robin,
// fixed priority with a 3-cycle gap) share one set of source inputs; each test checks one instance.
module tb_net_tx_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [23:0] srcData;
    logic [2:0]  srcValid;
    logic [2:0]  srcLast;
    logic        macReady;

    logic [1:0]  fpReady, gpReady, fpGrant, gpGrant;
    logic [2:0]  rrReady, rrGrant;
    logic [7:0]  fpData, rrData, gpData;
    logic        fpValid, rrValid, gpValid;
    logic        fpLast, rrLast, gpLast;
    logic        fpBusy, rrBusy, gpBusy;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct packed {
        logic [1:0]  dut;
        logic [2:0]  valid;
        logic [2:0]  last;
        logic [23:0] data;
        logic        ready;
        logic        eValid;
        logic        eLast;
        logic [7:0]  eData;
        logic [2:0]  eGrant;
        logic [2:0]  eReady;
        logic        eBusy;
    } vec_t;

    vec_t vecQ[$];

    always #5 clock = ~clock;

    net_tx_arbiter #(.CH_NUM(2), .DATA_WIDTH(8), .ARB_MODE(0), .IFG_CYCLES(0)) uFp (
        .logic_clk(clock), .logic_rst(reset),
        .src_data_in(srcData[15:0]), .src_valid_in(srcValid[1:0]),
        .src_ready_out(fpReady), .src_last_in(srcLast[1:0]),
        .net_tmac_data_out(fpData), .net_tmac_valid_out(fpValid),
        .net_tmac_ready_in(macReady), .net_tmac_last_out(fpLast),
        .grant_out(fpGrant), .busy_out(fpBusy)
    );

    net_tx_arbiter #(.CH_NUM(3), .DATA_WIDTH(8), .ARB_MODE(1), .IFG_CYCLES(0)) uRr (
        .logic_clk(clock), .logic_rst(reset),
        .src_data_in(srcData), .src_valid_in(srcValid),
        .src_ready_out(rrReady), .src_last_in(srcLast),
        .net_tmac_data_out(rrData), .net_tmac_valid_out(rrValid),
        .net_tmac_ready_in(macReady), .net_tmac_last_out(rrLast),
        .grant_out(rrGrant), .busy_out(rrBusy)
    );

    net_tx_arbiter #(.CH_NUM(2), .DATA_WIDTH(8), .ARB_MODE(0), .IFG_CYCLES(3)) uGap (
        .logic_clk(clock), .logic_rst(reset),
        .src_data_in(srcData[15:0]), .src_valid_in(srcValid[1:0]),
        .src_ready_out(gpReady), .src_last_in(srcLast[1:0]),
        .net_tmac_data_out(gpData), .net_tmac_valid_out(gpValid),
        .net_tmac_ready_in(macReady), .net_tmac_last_out(gpLast),
        .grant_out(gpGrant), .busy_out(gpBusy)
    );

    function automatic vec_t makeVec(input logic [1:0] dut, input logic [2:0] valid,
                                     input logic [2:0] last, input logic [23:0] data,
                                     input logic ready, input logic eValid, input logic eLast,
                                     input logic [7:0] eData, input logic [2:0] eGrant,
                                     input logic [2:0] eReady, input logic eBusy);
        vec_t v;
        v.dut = dut;       v.valid = valid;   v.last = last;     v.data = data;
        v.ready = ready;   v.eValid = eValid; v.eLast = eLast;   v.eData = eData;
        v.eGrant = eGrant; v.eReady = eReady; v.eBusy = eBusy;
        return v;
    endfunction

    function automatic void addVec(input logic [1:0] dut, input logic [2:0] valid,
                                   input logic [2:0] last, input logic [23:0] data,
                                   input logic ready, input logic eValid, input logic eLast,
                                   input logic [7:0] eData, input logic [2:0] eGrant,
                                   input logic [2:0] eReady, input logic eBusy);
        vecQ.push_back(makeVec(dut, valid, last, data, ready, eValid, eLast, eData,
                               eGrant, eReady, eBusy));
    endfunction

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        srcValid = v.valid;
        srcLast  = v.last;
        srcData  = v.data;
        macReady = v.ready;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        logic [7:0] aData;
        logic       aValid, aLast, aBusy;
        logic [2:0] aGrant, aReady;
        case (v.dut)
            2'd0: begin
                aData = fpData; aValid = fpValid; aLast = fpLast; aBusy = fpBusy;
                aGrant = {1'b0, fpGrant}; aReady = {1'b0, fpReady};
            end
            2'd1: begin
                aData = rrData; aValid = rrValid; aLast = rrLast; aBusy = rrBusy;
                aGrant = rrGrant; aReady = rrReady;
            end
            default: begin
                aData = gpData; aValid = gpValid; aLast = gpLast; aBusy = gpBusy;
                aGrant = {1'b0, gpGrant}; aReady = {1'b0, gpReady};
            end
        endcase
        checkEq({tag, ".valid"}, 32'(aValid), 32'(v.eValid));
        checkEq({tag, ".last"},  32'(aLast),  32'(v.eLast));
        checkEq({tag, ".data"},  32'(aData),  32'(v.eData));
        checkEq({tag, ".grant"}, 32'(aGrant), 32'(v.eGrant));
        checkEq({tag, ".ready"}, 32'(aReady), 32'(v.eReady));
        checkEq({tag, ".busy"},  32'(aBusy),  32'(v.eBusy));
    endtask

    // Drives at posedge+1, samples at the following negedge, returns at the next posedge+1.
    task automatic runVec(input vec_t v, input string tag);
        applyStimulus(v);
        @(negedge clock);
        checkOutput(v, tag);
        @(posedge clock);
        #1;
    endtask

    task automatic runTable(input string name);
        for (int i = 0; i < vecQ.size(); i++)
            runVec(vecQ[i], $sformatf("%s[%0d]", name, i));
        vecQ.delete();
    endtask

    task automatic resetDuts();
        reset    = 1'b1;
        srcValid = '0;
        srcLast  = '0;
        srcData  = '0;
        macReady = 1'b1;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [23:0] beat1Data;
        int          ch;

        // Requests held high during reset must not leak through.
        reset    = 1'b1;
        srcValid = 3'b111;
        srcLast  = 3'b111;
        srcData  = 24'h5A5A5A;
        macReady = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        for (int d = 0; d < 3; d++)
            checkOutput(makeVec(2'(d), 3'b111, 3'b111, 24'h5A5A5A, 1'b1,
                                0, 0, 8'h00, 3'b000, 3'b000, 0), $sformatf("reset.dut%0d", d));
        @(posedge clock);
        #1;

        // Fixed priority: ch0 frame A0..A3 first, one idle cycle, then ch1 frame B0..B3.
        resetDuts();
        addVec(0, 3'b011, 3'b000, {8'h00, 8'hB0, 8'hA0}, 1, 0, 0, 8'h00, 3'b000, 3'b000, 0);
        addVec(0, 3'b011, 3'b000, {8'h00, 8'hB0, 8'hA0}, 1, 1, 0, 8'hA0, 3'b001, 3'b001, 1);
        addVec(0, 3'b011, 3'b000, {8'h00, 8'hB0, 8'hA1}, 1, 1, 0, 8'hA1, 3'b001, 3'b001, 1);
        addVec(0, 3'b011, 3'b000, {8'h00, 8'hB0, 8'hA2}, 1, 1, 0, 8'hA2, 3'b001, 3'b001, 1);
        addVec(0, 3'b011, 3'b001, {8'h00, 8'hB0, 8'hA3}, 1, 1, 1, 8'hA3, 3'b001, 3'b001, 1);
        addVec(0, 3'b010, 3'b000, {8'h00, 8'hB0, 8'h00}, 1, 0, 0, 8'h00, 3'b000, 3'b000, 0);
        addVec(0, 3'b010, 3'b000, {8'h00, 8'hB0, 8'h00}, 1, 1, 0, 8'hB0, 3'b010, 3'b010, 1);
        addVec(0, 3'b010, 3'b000, {8'h00, 8'hB1, 8'h00}, 1, 1, 0, 8'hB1, 3'b010, 3'b010, 1);
        addVec(0, 3'b010, 3'b000, {8'h00, 8'hB2, 8'h00}, 1, 1, 0, 8'hB2, 3'b010, 3'b010, 1);
        addVec(0, 3'b010, 3'b010, {8'h00, 8'hB3, 8'h00}, 1, 1, 1, 8'hB3, 3'b010, 3'b010, 1);
        addVec(0, 3'b000, 3'b000, {8'h00, 8'h00, 8'h00}, 1, 0, 0, 8'h00, 3'b000, 3'b000, 0);
        runTable("fixedPrio");

        // Stall: ch1 drops valid for 3 cycles while ch0 waits; MAC ready toggles.
        resetDuts();
        addVec(0, 3'b010, 3'b000, {8'h00, 8'hC0, 8'h00}, 1, 0, 0, 8'h00, 3'b000, 3'b000, 0);
        addVec(0, 3'b010, 3'b000, {8'h00, 8'hC0, 8'h00}, 0, 1, 0, 8'hC0, 3'b010, 3'b000, 1);
        addVec(0, 3'b010, 3'b000, {8'h00, 8'hC0, 8'h00}, 1, 1, 0, 8'hC0, 3'b010, 3'b010, 1);
        addVec(0, 3'b001, 3'b000, {8'h00, 8'hC1, 8'hD0}, 1, 0, 0, 8'hC1, 3'b010, 3'b010, 1);
        addVec(0, 3'b001, 3'b000, {8'h00, 8'hC1, 8'hD0}, 0, 0, 0, 8'hC1, 3'b010, 3'b000, 1);
        addVec(0, 3'b001, 3'b000, {8'h00, 8'hC1, 8'hD0}, 1, 0, 0, 8'hC1, 3'b010, 3'b010, 1);
        addVec(0, 3'b011, 3'b000, {8'h00, 8'hC1, 8'hD0}, 1, 1, 0, 8'hC1, 3'b010, 3'b010, 1);
        addVec(0, 3'b011, 3'b000, {8'h00, 8'hC2, 8'hD0}, 0, 1, 0, 8'hC2, 3'b010, 3'b000, 1);
        addVec(0, 3'b011, 3'b000, {8'h00, 8'hC2, 8'hD0}, 1, 1, 0, 8'hC2, 3'b010, 3'b010, 1);
        addVec(0, 3'b011, 3'b010, {8'h00, 8'hC3, 8'hD0}, 1, 1, 1, 8'hC3, 3'b010, 3'b010, 1);
        addVec(0, 3'b001, 3'b001, {8'h00, 8'h00, 8'hD0}, 1, 0, 0, 8'h00, 3'b000, 3'b000, 0);
        addVec(0, 3'b001, 3'b001, {8'h00, 8'h00, 8'hD0}, 1, 1, 1, 8'hD0, 3'b001, 3'b001, 1);
        addVec(0, 3'b000, 3'b000, {8'h00, 8'h00, 8'h00}, 1, 0, 0, 8'h00, 3'b000, 3'b000, 0);
        runTable("stall");

        // Gap of 3: single-beat frame, immediate next request, 3 gap cycles + 1 idle cycle.
        resetDuts();
        addVec(2, 3'b001, 3'b001, {8'h00, 8'h00, 8'hE0}, 1, 0, 0, 8'h00, 3'b000, 3'b000, 0);
        addVec(2, 3'b001, 3'b001, {8'h00, 8'h00, 8'hE0}, 1, 1, 1, 8'hE0, 3'b001, 3'b001, 1);
        addVec(2, 3'b010, 3'b010, {8'h00, 8'hF0, 8'h00}, 1, 0, 0, 8'h00, 3'b000, 3'b000, 1);
        addVec(2, 3'b010, 3'b010, {8'h00, 8'hF0, 8'h00}, 1, 0, 0, 8'h00, 3'b000, 3'b000, 1);
        addVec(2, 3'b010, 3'b010, {8'h00, 8'hF0, 8'h00}, 1, 0, 0, 8'h00, 3'b000, 3'b000, 1);
        addVec(2, 3'b010, 3'b010, {8'h00, 8'hF0, 8'h00}, 1, 0, 0, 8'h00, 3'b000, 3'b000, 0);
        addVec(2, 3'b010, 3'b010, {8'h00, 8'hF0, 8'h00}, 1, 1, 1, 8'hF0, 3'b010, 3'b010, 1);
        addVec(2, 3'b000, 3'b000, {8'h00, 8'h00, 8'h00}, 1, 0, 0, 8'h00, 3'b000, 3'b000, 1);
        addVec(2, 3'b000, 3'b000, {8'h00, 8'h00, 8'h00}, 1, 0, 0, 8'h00, 3'b000, 3'b000, 1);
        addVec(2, 3'b000, 3'b000, {8'h00, 8'h00, 8'h00}, 1, 0, 0, 8'h00, 3'b000, 3'b000, 1);
        addVec(2, 3'b000, 3'b000, {8'h00, 8'h00, 8'h00}, 1, 0, 0, 8'h00, 3'b000, 3'b000, 0);
        runTable("gap");

        // Round-robin over 3 always-requesting channels with 2-beat frames: grants 0,1,2,0,1,2.
        resetDuts();
        for (int f = 0; f < 6; f++) begin
            ch = f % 3;
            beat1Data = 24'h201000;
            beat1Data[ch*8 +: 8] = 8'(ch * 16 + 1);
            runVec(makeVec(1, 3'b111, 3'b000, 24'h201000, 1,
                           0, 0, 8'h00, 3'b000, 3'b000, 0), $sformatf("rr.f%0d.idle", f));
            runVec(makeVec(1, 3'b111, 3'b000, 24'h201000, 1,
                           1, 0, 8'(ch * 16), 3'(1 << ch), 3'(1 << ch), 1), $sformatf("rr.f%0d.b0", f));
            runVec(makeVec(1, 3'b111, 3'(1 << ch), beat1Data, 1,
                           1, 1, 8'(ch * 16 + 1), 3'(1 << ch), 3'(1 << ch), 1), $sformatf("rr.f%0d.b1", f));
        end

        // Reset mid-frame: advance rr pointer to 1, start a 5-beat ch1 frame, reset on beat 2.
        resetDuts();
        runVec(makeVec(1, 3'b001, 3'b001, 24'h000001, 1, 0, 0, 8'h00, 3'b000, 3'b000, 0), "rst.idle0");
        runVec(makeVec(1, 3'b001, 3'b001, 24'h000001, 1, 1, 1, 8'h01, 3'b001, 3'b001, 1), "rst.single");
        runVec(makeVec(1, 3'b010, 3'b000, 24'h00A000, 1, 0, 0, 8'h00, 3'b000, 3'b000, 0), "rst.idle1");
        runVec(makeVec(1, 3'b010, 3'b000, 24'h00A000, 1, 1, 0, 8'hA0, 3'b010, 3'b010, 1), "rst.g0");
        runVec(makeVec(1, 3'b010, 3'b000, 24'h00A100, 1, 1, 0, 8'hA1, 3'b010, 3'b010, 1), "rst.g1");
        reset = 1'b1;
        runVec(makeVec(1, 3'b010, 3'b000, 24'h00A200, 1, 1, 0, 8'hA2, 3'b010, 3'b010, 1), "rst.g2");
        reset = 1'b0;
        runVec(makeVec(1, 3'b111, 3'b000, 24'h626160, 1, 0, 0, 8'h00, 3'b000, 3'b000, 0), "rst.after");
        runVec(makeVec(1, 3'b111, 3'b000, 24'h626160, 1, 1, 0, 8'h60, 3'b001, 3'b001, 1), "rst.fresh");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
